// File: rtl/ifu_fetch.sv
// ifu_fetch -- instruction-fetch unit for the five-stage RV64 pipeline.
// Owns the PC and fetches one 32-bit instruction at a time over a
// req/gnt/rvalid memory port. It keeps at most one request outstanding and
// delivers {pc, inst} through a single-entry IF/ID buffer with a valid/ready
// handshake. EX redirects overwrite the PC and squash any in-flight fetch.
//
// Optional feature: define IFU_MISALIGN_EXC_EN so that a redirect to a target
// that is not 4-byte aligned produces a single trap beat (pc = target,
// inst = NOP, if_misalign_o = 1) and fetch then parks until the next redirect.
// Without it, redirect targets are force-aligned and if_misalign_o is tied low.
module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [63:0] jump_addr_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [63:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_misalign_o
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_TRAP
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        buf_valid_q, buf_valid_d;
  logic [63:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;

  logic        req;
  logic        fire;
  logic        load_fetch;
  logic        inflight;
  logic        jump_trap;
  logic [63:0] jump_pc;

  // A new request may only go out when the buffer will have room for its
  // response; with one request outstanding this keeps the buffer from
  // ever overflowing.
  assign req  = (state_q == ST_REQ) && (!buf_valid_q || if_ready_i);
  assign fire = req && imem_gnt_i;

  // A good (not killed, not redirected) response lands in the buffer.
  assign load_fetch = (state_q == ST_WAIT) && imem_rvalid_i && !kill_q && !jump_en_i;

  // True when a memory response will still be owed after this clock edge:
  // either a request is granted right now, or one granted earlier has not
  // come back yet. A redirect must kill exactly that response.
  assign inflight = fire ||
                    (!imem_rvalid_i &&
                     ((state_q == ST_WAIT) || ((state_q == ST_TRAP) && kill_q)));

  // Aligned PC for a redirect; the low two bits are never fetched from.
  assign jump_pc = jump_addr_i & ~64'h3;

`ifdef IFU_MISALIGN_EXC_EN
  logic buf_mis_q;

  assign jump_trap     = jump_en_i && (jump_addr_i[1:0] != 2'b00);
  assign if_misalign_o = buf_mis_q;

  // Misaligned-target flag travels with the buffered beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_mis_q <= 1'b0;
    end else if (jump_en_i) begin
      buf_mis_q <= jump_trap;
    end else if (load_fetch) begin
      buf_mis_q <= 1'b0;
    end
  end
`else
  assign jump_trap     = 1'b0;
  assign if_misalign_o = 1'b0;
`endif

  // Next-state logic: normal fetch progress first, redirect applied last so
  // it overrides every other event in the same cycle.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    buf_valid_d = buf_valid_q;
    buf_pc_d    = buf_pc_q;
    buf_inst_d  = buf_inst_q;

    // IF/ID consumes the current beat.
    if (buf_valid_q && if_ready_i) begin
      buf_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (fire) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          state_d = ST_REQ;
          if (kill_q) begin
            kill_d = 1'b0;
          end else begin
            buf_valid_d = 1'b1;
            buf_pc_d    = pc_q;
            buf_inst_d  = imem_rdata_i;
            pc_d        = pc_q + 64'd4;
          end
        end
      end
      ST_TRAP: begin
        // A request granted just before the trap may still return here.
        if (imem_rvalid_i) begin
          kill_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (jump_en_i) begin
      pc_d        = jump_pc;
      buf_valid_d = 1'b0;
      kill_d      = inflight;
      if (jump_trap) begin
        state_d     = ST_TRAP;
        buf_valid_d = 1'b1;
        buf_pc_d    = jump_addr_i;
        buf_inst_d  = NOP_INST;
      end else if (inflight) begin
        state_d = ST_WAIT;
      end else begin
        state_d = ST_REQ;
      end
    end
  end

  // State, PC, kill flag and output buffer registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= '0;
      buf_inst_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      buf_valid_q <= buf_valid_d;
      buf_pc_q    <= buf_pc_d;
      buf_inst_q  <= buf_inst_d;
    end
  end

  assign imem_req_o  = req;
  assign imem_addr_o = pc_q;
  assign if_valid_o  = buf_valid_q;
  assign if_pc_o     = buf_pc_q;
  assign if_inst_o   = buf_inst_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch -- self-checking bench for ifu_fetch.
// Directed scenarios for reset, throughput, back-pressure, redirect corner
// cases and reset during a fetch, then randomized traffic. A memory model
// returns a fixed function of the address so any wrong-path or stale data is
// visible, and a stream-level model predicts every IF/ID beat.
module tb_ifu_fetch;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_en_i = 1'b0;
  logic [63:0] jump_addr_i = '0;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        if_valid_o;
  logic        if_ready_i = 1'b0;
  logic [63:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_misalign_o;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .jump_en_i    (jump_en_i),
    .jump_addr_i  (jump_addr_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .if_valid_o   (if_valid_o),
    .if_ready_i   (if_ready_i),
    .if_pc_o      (if_pc_o),
    .if_inst_o    (if_inst_o),
    .if_misalign_o(if_misalign_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
    end
  endtask

  // Instruction memory contents: a fixed, address-dependent pattern.
  function automatic logic [31:0] mem_fn(input logic [63:0] a);
    return a[31:0] ^ {a[47:32], a[63:48]} ^ 32'h5a5a_3c3c;
  endfunction

  // Whether a redirect to this target should produce a trap beat.
  function automatic bit trap_jump(input logic [63:0] a);
`ifdef IFU_MISALIGN_EXC_EN
    return a[1:0] != 2'b00;
`else
    return (a[1:0] != 2'b00) && 1'b0;
`endif
  endfunction

  // Memory model controls and state.
  bit          gnt_all = 1'b1;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          force_en = 1'b0;
  logic [31:0] force_data = '0;
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [63:0] mem_addr = '0;

  // Stream model: next expected beat.
  logic [63:0] exp_pc = RESET_PC;
  int          exp_kind = 0;      // 0 normal stream, 1 trap beat owed, 2 parked
  logic [63:0] trap_addr = '0;
  bit          trap_mode = 1'b0;
  bit          chk_flush = 1'b0;
  bit          after_rst = 1'b0;
  int          beats = 0;

  // Pre-edge samples of the DUT outputs.
  logic        s_req, s_valid, s_mis;
  logic [63:0] s_addr, s_pc;
  logic [31:0] s_inst;

  // Evaluate the cycle just before the rising edge against the model.
  task automatic scoreboard();
    s_req   = imem_req_o;
    s_addr  = imem_addr_o;
    s_valid = if_valid_o;
    s_pc    = if_pc_o;
    s_inst  = if_inst_o;
    s_mis   = if_misalign_o;
    if (rst) begin
      exp_pc    = RESET_PC;
      exp_kind  = 0;
      trap_mode = 1'b0;
      chk_flush = 1'b0;
      after_rst = 1'b1;
      return;
    end
    if (after_rst) begin
      check("rst_req", s_req, 0);
      check("rst_addr", s_addr, RESET_PC);
      check("rst_valid", s_valid, 0);
      check("rst_pc", s_pc, 0);
      check("rst_inst", s_inst, 0);
      check("rst_mis", s_mis, 0);
      after_rst = 1'b0;
    end
    if (chk_flush) check("flush_valid", s_valid, 0);
    if (trap_mode) check("trap_req", s_req, 0);
    if (s_valid && !if_ready_i) check("bp_req", s_req, 0);
    if (s_req && mem_busy) check("one_outstanding", s_req, 0);
    if (s_valid) begin
      if (exp_kind == 1) begin
        check("trap_pc", s_pc, trap_addr);
        check("trap_inst", s_inst, NOP_INST);
        check("trap_mis", s_mis, 1);
      end else if (exp_kind == 2) begin
        check("parked_valid", s_valid, 0);
      end else begin
        check("beat_pc", s_pc, exp_pc);
        check("beat_inst", s_inst, mem_fn(exp_pc));
        check("beat_mis", s_mis, 0);
      end
      if (if_ready_i && !jump_en_i) begin
        beats++;
        if (exp_kind == 1) exp_kind = 2;
        else if (exp_kind == 0) exp_pc = exp_pc + 64'd4;
      end
    end
    chk_flush = jump_en_i && !trap_jump(jump_addr_i);
    if (jump_en_i) begin
      if (trap_jump(jump_addr_i)) begin
        exp_kind  = 1;
        trap_addr = jump_addr_i;
        trap_mode = 1'b1;
      end else begin
        exp_pc    = jump_addr_i & ~64'h3;
        exp_kind  = 0;
        trap_mode = 1'b0;
      end
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, run the memory
  // model, then evaluate before the next rising edge.
  task automatic cycle(input bit rdy, input bit jmp = 1'b0,
                       input logic [63:0] ja = '0, input bit rs = 1'b0);
    @(negedge clk);
    rst           = rs;
    if_ready_i    = rdy;
    jump_en_i     = jmp;
    jump_addr_i   = ja;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_busy      = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = force_en ? force_data : mem_fn(mem_addr);
      end
    end
    #1;
    scoreboard();
    imem_gnt_i = imem_req_o && (gnt_all || ($urandom_range(0, 9) < 7));
    if (imem_gnt_i) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr_o;
      mem_cnt  = $urandom_range(lat_min, lat_max);
    end
    #1;
  endtask

  task automatic run_until_req(input string tag, input logic [63:0] want_addr, output int n);
    n = 0;
    do begin
      cycle(1'b1);
      n++;
    end while (!s_req && n < 20);
    check({tag, "_req"}, s_req, 1);
    check({tag, "_addr"}, s_addr, want_addr);
  endtask

  task automatic run_until_valid(input string tag, input logic [63:0] want_pc);
    int n = 0;
    do begin
      cycle(1'b1);
      n++;
    end while (!s_valid && n < 20);
    check({tag, "_valid"}, s_valid, 1);
    check({tag, "_pc"}, s_pc, want_pc);
    check({tag, "_inst"}, s_inst, mem_fn(want_pc));
  endtask

  initial begin
    int          n;
    logic [63:0] base;
    logic [31:0] r;
    logic [63:0] ja;

    cycle(1'b1, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b1);

    // Straight-line fetch: one beat every two cycles.
    cycle(1'b1);
    check("t1_idle_req", s_req, 0);
    cycle(1'b1);
    check("t1_req0", s_req, 1);
    check("t1_addr0", s_addr, 64'h8000_0000);
    cycle(1'b1);
    check("t1_wait_req", s_req, 0);
    cycle(1'b1);
    check("t1_b0_valid", s_valid, 1);
    check("t1_b0_pc", s_pc, 64'h8000_0000);
    check("t1_addr1", s_addr, 64'h8000_0004);
    cycle(1'b1);
    check("t1_gap_valid", s_valid, 0);
    cycle(1'b1);
    check("t1_b1_valid", s_valid, 1);
    check("t1_b1_pc", s_pc, 64'h8000_0004);
    check("t1_addr2", s_addr, 64'h8000_0008);

    // Back-pressure with a full buffer.
    cycle(1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0);
      check("t2_hold_req", s_req, 0);
      check("t2_hold_pc", s_pc, 64'h8000_0008);
      check("t2_hold_inst", s_inst, mem_fn(64'h8000_0008));
    end
    lat_min    = 3;
    lat_max    = 3;
    force_en   = 1'b1;
    force_data = 32'hDEAD_BEEF;
    cycle(1'b1);
    check("t2_resume_req", s_req, 1);
    check("t2_resume_addr", s_addr, 64'h8000_000C);

    // Redirect while waiting; the late response must be dropped.
    cycle(1'b1, 1'b1, 64'h8000_1000);
    lat_min = 1;
    lat_max = 1;
    run_until_req("t3", 64'h8000_1000, n);
    check("t3_kill_wait", n, 3);
    force_en = 1'b0;
    run_until_valid("t3_beat", 64'h8000_1000);

    // Redirect coincident with rvalid.
    cycle(1'b1, 1'b1, 64'h8000_2000);
    cycle(1'b1);
    check("t4a_valid", s_valid, 0);
    check("t4a_req", s_req, 1);
    check("t4a_addr", s_addr, 64'h8000_2000);

    // Redirect coincident with req && gnt.
    cycle(1'b1);
    cycle(1'b1, 1'b1, 64'h8000_3000);
    check("t4b_req", s_req, 1);
    cycle(1'b1);
    check("t4b_kill_valid", s_valid, 0);
    check("t4b_kill_req", s_req, 0);
    cycle(1'b1);
    check("t4b_req_tgt", s_req, 1);
    check("t4b_addr_tgt", s_addr, 64'h8000_3000);
    check("t4b_valid", s_valid, 0);
    run_until_valid("t4b_beat", 64'h8000_3000);

    // Misaligned redirect target.
    cycle(1'b1, 1'b1, 64'h8000_0002);
`ifdef IFU_MISALIGN_EXC_EN
    cycle(1'b1);
    check("t5_trap_valid", s_valid, 1);
    check("t5_trap_pc", s_pc, 64'h8000_0002);
    check("t5_trap_inst", s_inst, NOP_INST);
    check("t5_trap_mis", s_mis, 1);
    check("t5_trap_req", s_req, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1);
      check("t5_park_req", s_req, 0);
      check("t5_park_valid", s_valid, 0);
    end
    cycle(1'b1, 1'b1, 64'h8000_0100);
    base = 64'h8000_0100;
`else
    base = 64'h8000_0000;
`endif
    run_until_req("t5", base, n);
    run_until_valid("t5_beat", base);

    // Reset pulsed mid-WAIT; the late response lands in IDLE.
    cycle(1'b1);
    lat_min = 2;
    lat_max = 2;
    run_until_req("t6_pre", base + 64'd8, n);
    cycle(1'b1, 1'b0, '0, 1'b1);
    lat_min = 1;
    lat_max = 1;
    cycle(1'b1);
    check("t6_idle_req", s_req, 0);
    run_until_req("t6", RESET_PC, n);
    check("t6_req_delay", n, 1);
    run_until_valid("t6_beat", RESET_PC);

    // Randomized traffic.
    gnt_all = 1'b0;
    lat_min = 1;
    lat_max = 3;
    beats   = 0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      if (r[4:0] == 5'd0) begin
        case (r[6:5])
          2'd0:    ja = {32'h0, 32'hFFFF_FFF0 | {28'h0, r[10:7]}};
          2'd1:    ja = 64'hFFFF_FFFF_FFFF_FFF0 | {60'h0, r[10:7]};
          default: ja = {32'h0, 16'h8000, r[31:16]};
        endcase
        if (r[13:11] != 3'd0) ja[1:0] = 2'b00;
        cycle($urandom_range(0, 3) != 0, 1'b1, ja);
      end else begin
        cycle($urandom_range(0, 3) != 0);
      end
    end
    check("rand_progress", beats > 100, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction-fetch unit for the five-stage RV64 pipeline. Owns the PC register and fetches one 32-bit instruction at a time from instruction memory over a req/gnt/rvalid interface. Delivers pc+instruction to the IF/ID register with a valid/ready handshake. Consumes the EX-stage branch/jump redirect (jump enable + target), squashing wrong-path fetches already in flight.

## Interface
- RESET_PC, 64'h8000_0000, first fetch address after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- jump_en_i  in  1  redirect pulse from EX (taken branch / jal / jalr)
- jump_addr_i  in  64  redirect target, valid when jump_en_i=1
- imem_req_o  out  1  fetch request
- imem_addr_o  out  64  fetch address, meaningful when imem_req_o=1
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response data valid; never back-pressured
- imem_rdata_i  in  32  fetched instruction
- if_valid_o  out  1  IF/ID beat valid
- if_ready_i  in  1  IF/ID accepts beat
- if_pc_o  out  64  pc of beat
- if_inst_o  out  32  instruction of beat
- if_misalign_o  out  1  beat carries misaligned-target exception

## Operation
- State machine: IDLE, REQ, WAIT, TRAP. Reset → IDLE; IDLE → REQ unconditionally next cycle.
- REQ: imem_req_o = (!buf_valid || if_ready_i); imem_addr_o = pc. On req&&gnt → WAIT. Address may change while ungranted; memory samples it only on gnt.
- WAIT: on imem_rvalid_i: if kill=0, load output buffer {pc, rdata}, pc ← pc+4 (64-bit wrap); if kill=1, discard and clear kill. Either case → REQ.
- Output buffer: single entry; if_valid_o = buf_valid; cleared when if_valid_o&&if_ready_i. At most one outstanding request, so buffer never overflows.
- Redirect (jump_en_i=1) has priority over every other event in the same cycle:
  - pc ← jump_addr_i; buf_valid ← 0 (beat dropped even if if_ready_i=1 same cycle — EX owns the flush).
  - In WAIT without rvalid this cycle: kill ← 1, stay WAIT.
  - In WAIT with rvalid this cycle: response discarded, → REQ.
  - In REQ with req&&gnt this cycle: kill ← 1, → WAIT (granted wrong-path request dropped on return).
  - In REQ without gnt: stay REQ, new address presented next cycle.
  - In TRAP: → REQ (or TRAP again per Configuration).
- Two consecutive redirects: last one wins; kill remains a single bit (one outstanding request max).

## Timing
- Reset values: imem_req_o=0, imem_addr_o=RESET_PC, if_valid_o=0, if_pc_o=0, if_inst_o=0, if_misalign_o=0, kill=0, pc=RESET_PC.
- First imem_req_o=1 on the second cycle after rst falls (IDLE cycle, then REQ).
- gnt at cycle N → rvalid earliest N+1 → if_valid_o at N+2. Peak throughput: one instruction per 2 cycles.
- Redirect at cycle N → imem_addr_o=jump target at N+1 if in REQ; if_valid_o=0 at N+1.
- rst asserted mid-WAIT: state, kill, buffer cleared; late rvalid arriving in IDLE is ignored.

## Configuration
- IFU_MISALIGN_EXC_EN defined: redirect with jump_addr_i[1:0]≠0 → no fetch issued; → TRAP, buffer loaded with if_pc_o=jump_addr_i, if_inst_o=32'h0000_0013, if_misalign_o=1. TRAP holds (imem_req_o=0) until next redirect; beat consumed normally.
- Not defined: pc ← {jump_addr_i[63:2],2'b00}, fetch proceeds normally; TRAP unreachable; if_misalign_o tied 0.

## Test plan
- Reset, gnt=1 always, rvalid one cycle after gnt, ready=1 → imem_addr_o sequence 0x80000000, 0x80000004, 0x80000008; if_pc_o matches, one beat per 2 cycles.
- Hold if_ready_i=0 for 5 cycles with buffer full → imem_req_o=0, if_pc_o/if_inst_o stable; ready=1 → req resumes same cycle.
- Redirect to 0x80001000 in WAIT, rvalid 3 cycles later with 0xDEADBEEF → that data never appears; next imem_addr_o=0x80001000.
- Redirect coincident with rvalid and with req&&gnt respectively → response dropped, next fetch at target, no stale beat on IF/ID.
- With IFU_MISALIGN_EXC_EN: redirect to 0x80000002 → one beat if_misalign_o=1, if_pc_o=0x80000002, inst 0x00000013, no req until redirect to 0x80000100; without macro: fetch at 0x80000000.
- rst pulsed while WAIT, rvalid arrives during IDLE → ignored; first post-reset beat pc=0x80000000.
